// File: rtl/psum_acc_ctrl_if.sv
// Handshake and RAM-side bundle for the partial-sum accumulator controller.
// The controller connects to slave; the environment (RAM, producer, consumer) uses master.
interface psum_acc_ctrl_if #(
  parameter int DWIDTH = 24,
  parameter int AWIDTH = 8
);
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic              cmd_ready;

  logic              in_valid;
  logic              in_ready;
  logic [AWIDTH-1:0] in_addr;
  logic [DWIDTH-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;

  logic              ram_we;
  logic [AWIDTH-1:0] ram_adr_w;
  logic [DWIDTH-1:0] ram_dat_i;
  logic [AWIDTH-1:0] ram_adr_r;
  logic [DWIDTH-1:0] ram_dat_o2;

  logic              busy;
  logic              done;
  logic              sat_flag;

  modport master (
    output cmd_valid, cmd_op, in_valid, in_addr, in_data, in_last, out_ready, ram_dat_o2,
    input  cmd_ready, in_ready, out_valid, out_data, out_last,
           ram_we, ram_adr_w, ram_dat_i, ram_adr_r, busy, done, sat_flag
  );

  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_addr, in_data, in_last, out_ready, ram_dat_o2,
    output cmd_ready, in_ready, out_valid, out_data, out_last,
           ram_we, ram_adr_w, ram_dat_i, ram_adr_r, busy, done, sat_flag
  );
endinterface

// File: rtl/psum_acc_ctrl.sv
// Partial-sum accumulator controller: clears, accumulates into and drains an external
// 1-cycle-latency read-before-write RAM.
module psum_acc_ctrl #(
  parameter int DWIDTH = 24,
  parameter int AWIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  psum_acc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACC, FLUSH, DRAIN} state_e;

  localparam logic [DWIDTH-1:0] SatMax   = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] SatMin   = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [AWIDTH-1:0] LastAddr = '1;

  state_e            state_q;
  logic [AWIDTH-1:0] ptr_q;
  logic              outValid_q;
  logic              pendValid_q;
  logic [AWIDTH-1:0] pendAddr_q;
  logic [DWIDTH-1:0] pendData_q;
  logic              fwdValid_q;
  logic [AWIDTH-1:0] fwdAddr_q;
  logic [DWIDTH-1:0] fwdData_q;
  logic              satFlag_q;
  logic              done_q;

  logic              cmdAccept;
  logic              inAccept;
  logic              drainAdv;
  logic [DWIDTH-1:0] operand;
  logic [DWIDTH:0]   sumWide;
  logic              overflow;
  logic [DWIDTH-1:0] wrData_d;
  logic [AWIDTH-1:0] rdAddr;

  assign cmdAccept = bus.cmd_valid && (state_q == IDLE);
  assign inAccept  = bus.in_valid && (state_q == ACC);
  assign drainAdv  = outValid_q && bus.out_ready;

  // The RAM read issued alongside the previous beat cannot see that beat's write, so forward it.
  assign operand  = (fwdValid_q && (fwdAddr_q == pendAddr_q)) ? fwdData_q : bus.ram_dat_o2;
  assign sumWide  = {operand[DWIDTH-1], operand} + {pendData_q[DWIDTH-1], pendData_q};
  assign overflow = sumWide[DWIDTH] ^ sumWide[DWIDTH-1];
  assign wrData_d = overflow ? (sumWide[DWIDTH] ? SatMin : SatMax) : sumWide[DWIDTH-1:0];

  // While draining, a stalled beat re-reads its own address so the RAM output holds steady.
  always_comb begin
    rdAddr = '0;
    if (state_q == ACC) begin
      rdAddr = bus.in_addr;
    end else if (state_q == DRAIN) begin
      rdAddr = drainAdv ? ptr_q + 1'b1 : ptr_q;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.in_ready  = (state_q == ACC);
  assign bus.ram_we    = pendValid_q || (state_q == CLEAR);
  assign bus.ram_adr_w = (state_q == CLEAR) ? ptr_q : pendAddr_q;
  assign bus.ram_dat_i = pendValid_q ? wrData_d : '0;
  assign bus.ram_adr_r = rdAddr;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outValid_q ? bus.ram_dat_o2 : '0;
  assign bus.out_last  = outValid_q && (ptr_q == LastAddr);
  assign bus.done      = done_q;
  assign bus.sat_flag  = satFlag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      outValid_q  <= 1'b0;
      pendValid_q <= 1'b0;
      pendAddr_q  <= '0;
      pendData_q  <= '0;
      fwdValid_q  <= 1'b0;
      fwdAddr_q   <= '0;
      fwdData_q   <= '0;
      satFlag_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      pendValid_q <= inAccept;
      if (inAccept) begin
        pendAddr_q <= bus.in_addr;
        pendData_q <= bus.in_data;
      end
      fwdValid_q <= pendValid_q;
      fwdAddr_q  <= pendAddr_q;
      fwdData_q  <= wrData_d;
      if (pendValid_q && overflow) begin
        satFlag_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cmdAccept) begin
            case (bus.cmd_op)
              2'b01: begin
                state_q   <= CLEAR;
                ptr_q     <= '0;
                satFlag_q <= 1'b0;
              end
              2'b10: state_q <= ACC;
              2'b11: begin
                state_q    <= DRAIN;
                ptr_q      <= '0;
                outValid_q <= 1'b0;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        CLEAR: begin
          if (ptr_q == LastAddr) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        ACC: begin
          if (inAccept && bus.in_last) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        DRAIN: begin
          if (!outValid_q) begin
            outValid_q <= 1'b1;
          end else if (bus.out_ready) begin
            if (ptr_q == LastAddr) begin
              outValid_q <= 1'b0;
              ptr_q      <= '0;
              state_q    <= IDLE;
              done_q     <= 1'b1;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/psum_acc_ctrl.md
PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 24: RAM word width, signed two's-complement partial sum.
REQ-002 SHALL have parameter AWIDTH, default 8: RAM address width; DEPTH = 2**AWIDTH.
REQ-003 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  in  1, cmd_op  in  2 (01 CLEAR, 10 ACC, 11 DRAIN, 00 ignored), and cmd_ready  out  1.
REQ-006 SHALL have ports in_valid  in  1, in_ready  out  1, in_addr  in  AWIDTH, in_data  in  DWIDTH, in_last  in  1: psum stream.
REQ-007 SHALL have ports out_valid  out  1, out_ready  in  1, out_data  out  DWIDTH, out_last  out  1: drain stream.
REQ-008 SHALL have RAM-side ports ram_we  out  1, ram_adr_w  out  AWIDTH, ram_dat_i  out  DWIDTH, ram_adr_r  out  AWIDTH, ram_dat_o2  in  DWIDTH; the RAM is external, with registered read data one cycle after the read address and read-before-write on the same edge.
REQ-009 SHALL have status ports busy  out  1, done  out  1 (one-cycle pulse), sat_flag  out  1 (sticky).

Function
REQ-010 SHALL implement states IDLE, CLEAR, ACC, FLUSH, DRAIN; cmd_ready = (state==IDLE); busy = !IDLE.
REQ-011 SHALL accept a command on cmd_valid && cmd_ready; op 01 -> CLEAR, 10 -> ACC, 11 -> DRAIN, 00 -> stay IDLE.
REQ-012 CLEAR: SHALL write 0 to addresses 0..DEPTH-1, one per cycle, in ascending order; SHALL clear sat_flag; after the write to DEPTH-1 SHALL go to IDLE with done pulsed for 1 cycle.
REQ-013 ACC: in_ready SHALL be 1; an accepted beat SHALL drive ram_adr_r = in_addr combinationally in the accept cycle.
REQ-014 ACC: in the cycle after acceptance, SHALL write ram_adr_w = beat address, ram_dat_i = sat(operand + beat data), ram_we = 1.
REQ-015 The operand SHALL be the last written word if the previous-edge write targeted the same address (forwarding); otherwise it SHALL be ram_dat_o2; back-to-back same-address beats SHALL accumulate with no lost update.
REQ-016 The sum SHALL be computed in DWIDTH+1 bits and clamped to [-2**(DWIDTH-1), 2**(DWIDTH-1)-1]; any clamp SHALL set sat_flag until the next CLEAR or reset.
REQ-017 An accepted beat with in_last SHALL move ACC -> FLUSH with in_ready = 0; FLUSH SHALL last 1 cycle, completing the final write, then go to IDLE with done pulsed.
REQ-018 ram_we SHALL be 0 in every cycle with no CLEAR or ACC write pending.
REQ-019 DRAIN: SHALL emit DEPTH beats, addresses 0..DEPTH-1 in order, with out_last on beat DEPTH-1; first out_valid SHALL come no later than 2 cycles after command acceptance.
REQ-020 DRAIN: SHALL sustain 1 beat/cycle while out_ready = 1.
REQ-021 DRAIN: out_data and out_last SHALL hold stable while out_valid && !out_ready, with no loss or duplication under any out_ready pattern.
REQ-022 DRAIN: after acceptance of the out_last beat, SHALL go to IDLE with done pulsed; DRAIN SHALL NOT modify RAM.
REQ-023 in_valid outside ACC SHALL be ignored; cmd_valid outside IDLE SHALL be ignored, never queued.

Reset
REQ-024 rst SHALL immediately force IDLE; cmd_ready = 1 after deassert; in_ready, out_valid, out_last, ram_we, done, busy, sat_flag = 0; out_data, ram_adr_w, ram_adr_r, ram_dat_i = 0; pipeline/forward valid bits = 0.
REQ-025 Reset mid-operation SHALL abandon the operation with no further RAM write; RAM contents are then undefined until the next CLEAR.

Verification (AWIDTH=8, DWIDTH=24)
REQ-026 Reset, CLEAR -> 256 cycles ram_we=1, data 0, addr 0..255, done 1 cycle; then DRAIN with out_ready=1 -> 256 zeros, out_last on beat 255.
REQ-027 CLEAR, ACC beats addr 5 data 10, 20, 30 back-to-back (last on 3rd), DRAIN -> entry 5 = 60, all others 0.
REQ-028 CLEAR, ACC addr 1 +3, addr 2 +4, addr 1 +5 -> entry 1 = 8, entry 2 = 4.
REQ-029 Saturation: addr 7 0x7FFFFF then 0x000001 -> 0x7FFFFF, sat_flag 1; addr 8 0x800000 then 0xFFFFFF -> 0x800000; next CLEAR -> sat_flag 0.
REQ-030 DRAIN of entries i = i (preloaded via ACC) with out_ready random 50% -> 256 beats 0..255 in order, stable during stalls.
REQ-031 rst asserted at drain beat 100 -> same-cycle out_valid 0, busy 0, ram_we 0; after deassert, cmd_ready 1 and a new CLEAR completes normally.
